// File: rtl/async_fifo_rd_pkg.sv
// Shared types and defaults for the async FIFO read-side drain stage.
package async_fifo_rd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int SKID_DEPTH = 2;
  localparam int DSIZE_DEF  = 8;
  localparam int CNTW_DEF   = 16;

endpackage

// File: rtl/async_fifo_rd_skid.sv
// Two-entry skid buffer: head_q feeds the stream, skid_q absorbs the word still
// in flight from the FIFO when the consumer stalls.
module async_fifo_rd_skid
  import async_fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [DSIZE-1:0] head,
  output occ_t             occ
);

  occ_t             occ_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;

  assign head = head_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ    <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Push into TWO without a pop cannot happen: the credit check upstream forbids it.
  always_comb begin
    occ_d  = occ;
    head_d = head_q;
    skid_d = skid_q;
    case (occ)
      EMPTY: begin
        if (push) begin
          head_d = push_data;
          occ_d  = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          skid_d = push_data;
          occ_d  = TWO;
        end else if (pop) begin
          occ_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d = skid_q;
          if (push) skid_d = push_data;
          else      occ_d  = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/async_fifo_rd_drain.sv
// Read-domain drain: pops the async FIFO and re-presents words as a valid/ready
// stream. Optional counters under ASYNC_FIFO_RD_STATS_EN.
module async_fifo_rd_drain
  import async_fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
`ifdef ASYNC_FIFO_RD_STATS_EN
  , parameter int CNTW = CNTW_DEF
`endif
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data
`ifdef ASYNC_FIFO_RD_STATS_EN
  , output logic [CNTW-1:0] rd_words
  , output logic [CNTW-1:0] stall_cycles
`endif
);

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic       rinc_raw;
  logic [2:0] lvl;

  assign m_valid = (occ != EMPTY);
  assign pop     = m_valid && m_ready;

  // Words held plus word in flight, minus the one leaving this cycle.
  assign lvl      = 3'(occ) + {2'b00, inflight} - {2'b00, pop};
  assign rinc_raw = !rempty && (lvl < 3'(SKID_DEPTH));
  assign rinc     = rinc_raw && rrst_n;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) inflight <= 1'b0;
    else         inflight <= rinc_raw;
  end

  async_fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (inflight),
    .push_data (rdata),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

`ifdef ASYNC_FIFO_RD_STATS_EN
  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_words     <= '0;
      stall_cycles <= '0;
    end else begin
      if (pop && (rd_words != '1))
        rd_words <= rd_words + 1'b1;
      if (m_valid && !m_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Bench for async_fifo_rd_drain: behavioural FIFO read port, per-cycle vector
// table, handshake scoreboard and multi-cycle corner sequences.
module tb_async_fifo_rd_drain;
  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          rempty = 1'b1;
  logic          hold_empty = 1'b0;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 rclk = ~rclk;

`ifdef ASYNC_FIFO_RD_STATS_EN
  logic [15:0]   rd_words, stall_cycles;
  logic [3:0]    rd_words4, stall_cycles4;
  logic          rinc4, m_valid4;
  logic [DW-1:0] m_data4;
`endif

  async_fifo_rd_drain #(.DSIZE(DW)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef ASYNC_FIFO_RD_STATS_EN
    , .rd_words(rd_words), .stall_cycles(stall_cycles)
`endif
  );

`ifdef ASYNC_FIFO_RD_STATS_EN
  async_fifo_rd_drain #(.DSIZE(DW), .CNTW(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .rd_words(rd_words4), .stall_cycles(stall_cycles4)
  );
`endif

  // FIFO read port model: registered read data, pointer reset with rrst_n.
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rdata <= '0;
    else if (rinc && fifo_q.size() > 0) rdata <= fifo_q.pop_front();
  end

  always @(negedge rclk) begin
    #1;
    rempty = hold_empty || (fifo_q.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and FIFO-protocol monitor, sampled mid-cycle.
  always @(negedge rclk) begin
    #2;
    if (rrst_n) begin
      if (rempty) chk("rinc_while_empty", {31'b0, rinc}, 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_extra: got %0h expected no word", m_data);
        end else begin
          chk("sb_data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic step(input logic rdy);
    @(negedge rclk);
    m_ready = rdy;
    #2;
  endtask

  task automatic apply_reset();
    rrst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    step(1'b0);
    step(1'b0);
    rrst_n = 1'b1;
  endtask

  typedef struct {
    logic          rdy;
    logic          rinc;
    logic          vld;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h11};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h22};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h33};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00};

    // Reset with data waiting: rinc must stay forced low.
    load(8'h11); load(8'h22); load(8'h33);
    step(1'b0);
    step(1'b0);
    chk("rst_rinc", {31'b0, rinc}, 32'd0);
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_data", {24'b0, m_data}, 32'd0);

    #1;
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("first_rinc", {31'b0, rinc}, 32'd1);
    chk("first_valid", {31'b0, m_valid}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      step(tbl[i].rdy);
      chk($sformatf("tbl%0d_rinc", i), {31'b0, rinc}, {31'b0, tbl[i].rinc});
      chk($sformatf("tbl%0d_valid", i), {31'b0, m_valid}, {31'b0, tbl[i].vld});
      if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), {24'b0, m_data}, {24'b0, tbl[i].data});
    end

    // Backpressure: only two pops, head holds the first word.
    for (int i = 0; i < 5; i++) load(8'hA1 + 8'(i));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      if (rinc) pulses++;
      if (m_valid) chk("bp_hold_data", {24'b0, m_data}, 32'hA1);
    end
    chk("bp_pulses", pulses, 32'd2);
    chk("bp_valid", {31'b0, m_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk("bp_no_gap", {31'b0, m_valid}, 32'd1);
    end
    step(1'b1);
    chk("bp_end_valid", {31'b0, m_valid}, 32'd0);
    chk("bp_drained", exp_q.size(), 32'd0);

    // rempty toggling with random backpressure.
    for (int i = 0; i < 8; i++) load(8'($urandom));
    for (int i = 0; i < 40; i++) begin
      hold_empty = i[0];
      step(1'($urandom_range(0, 1)));
    end
    hold_empty = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b1);
    chk("toggle_drained", exp_q.size(), 32'd0);

    // Reset mid-stream with a word in flight.
    for (int i = 0; i < 6; i++) load(8'hC0 + 8'(i));
    step(1'b1); step(1'b1); step(1'b1);
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, m_valid}, 32'd0);
    chk("mid_rst_rinc", {31'b0, rinc}, 32'd0);
    fifo_q.delete();
    exp_q.delete();
    step(1'b1);
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk("post_rst_valid", {31'b0, m_valid}, 32'd0);
    end
    load(8'h5A);
    for (int i = 0; i < 5; i++) step(1'b1);
    chk("post_rst_word", exp_q.size(), 32'd0);

    // Reset with the buffer full.
    load(8'h01); load(8'h02); load(8'h03);
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("full_before_rst", {31'b0, m_valid}, 32'd1);
    rrst_n = 1'b0;
    #1;
    chk("full_rst_valid", {31'b0, m_valid}, 32'd0);
    chk("full_rst_data", {24'b0, m_data}, 32'd0);
    fifo_q.delete();
    exp_q.delete();
    step(1'b1);
    rrst_n = 1'b1;
    step(1'b1);
    chk("full_post_valid", {31'b0, m_valid}, 32'd0);

`ifdef ASYNC_FIFO_RD_STATS_EN
    apply_reset();
    for (int i = 0; i < 10; i++) load(8'(i + 1));
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (m_valid) break;
    end
    step(1'b0); step(1'b0); step(1'b0);
    for (int i = 0; i < 15; i++) step(1'b1);
    chk("stat_rd_words", {16'b0, rd_words}, 32'd10);
    chk("stat_stalls", {16'b0, stall_cycles}, 32'd4);
    chk("stat4_stalls", {28'b0, stall_cycles4}, 32'd4);

    apply_reset();
    for (int i = 0; i < 20; i++) load(8'(i + 32));
    for (int i = 0; i < 25; i++) step(1'b1);
    chk("stat_rd_words20", {16'b0, rd_words}, 32'd20);
    chk("stat4_saturate", {28'b0, rd_words4}, 32'd15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
